// File: rtl/ysyx_23060077_riscv_axi_arbiter.sv
// Master-side AXI arbiter: IFU (read only) and LSU (read/write) share one AXI initiator port.
// One read and one write may be outstanding at a time; the read and write paths are independent.
// Optional build macro AXI_ARB_RR_EN: round-robin read arbitration. Without it, LSU has fixed priority.
//
// state  | meaning
// R_IDLE | no read in flight, arbitrating ar requests
// R_ADDR | presenting latched read address downstream
// R_DATA | waiting for R beat, routed to granted requester
// W_IDLE | no write in flight, waiting for LSU aw+w together
// W_REQ  | presenting latched aw/w downstream until both accepted
// W_RESP | forwarding B response to LSU
module ysyx_23060077_riscv_axi_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int STRB_WIDTH = 4,
    parameter int PORT_WIDTH = 3,
    parameter int RESP_WIDTH = 2
) (
    input  logic                  aclk,
    input  logic                  areset_n,
    input  logic                  ifu_ar_valid_i,
    output logic                  ifu_ar_ready_o,
    input  logic [PORT_WIDTH-1:0] ifu_ar_port_i,
    input  logic [ADDR_WIDTH-1:0] ifu_ar_addr_i,
    output logic                  ifu_r_valid_o,
    input  logic                  ifu_r_ready_i,
    output logic [RESP_WIDTH-1:0] ifu_r_resp_o,
    output logic [DATA_WIDTH-1:0] ifu_r_data_o,
    input  logic                  lsu_ar_valid_i,
    output logic                  lsu_ar_ready_o,
    input  logic [PORT_WIDTH-1:0] lsu_ar_port_i,
    input  logic [ADDR_WIDTH-1:0] lsu_ar_addr_i,
    output logic                  lsu_r_valid_o,
    input  logic                  lsu_r_ready_i,
    output logic [RESP_WIDTH-1:0] lsu_r_resp_o,
    output logic [DATA_WIDTH-1:0] lsu_r_data_o,
    input  logic                  lsu_aw_valid_i,
    output logic                  lsu_aw_ready_o,
    input  logic [PORT_WIDTH-1:0] lsu_aw_port_i,
    input  logic [ADDR_WIDTH-1:0] lsu_aw_addr_i,
    input  logic                  lsu_w_valid_i,
    output logic                  lsu_w_ready_o,
    input  logic [STRB_WIDTH-1:0] lsu_w_strb_i,
    input  logic [DATA_WIDTH-1:0] lsu_w_data_i,
    output logic                  lsu_b_valid_o,
    input  logic                  lsu_b_ready_i,
    output logic [RESP_WIDTH-1:0] lsu_b_resp_o,
    output logic                  axi_ar_valid_o,
    input  logic                  axi_ar_ready_i,
    output logic [PORT_WIDTH-1:0] axi_ar_port_o,
    output logic [ADDR_WIDTH-1:0] axi_ar_addr_o,
    input  logic                  axi_r_valid_i,
    output logic                  axi_r_ready_o,
    input  logic [RESP_WIDTH-1:0] axi_r_resp_i,
    input  logic [DATA_WIDTH-1:0] axi_r_data_i,
    output logic                  axi_aw_valid_o,
    input  logic                  axi_aw_ready_i,
    output logic [PORT_WIDTH-1:0] axi_aw_port_o,
    output logic [ADDR_WIDTH-1:0] axi_aw_addr_o,
    output logic                  axi_w_valid_o,
    input  logic                  axi_w_ready_i,
    output logic [STRB_WIDTH-1:0] axi_w_strb_o,
    output logic [DATA_WIDTH-1:0] axi_w_data_o,
    input  logic                  axi_b_valid_i,
    output logic                  axi_b_ready_o,
    input  logic [RESP_WIDTH-1:0] axi_b_resp_i
);

    typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} r_state_e;
    typedef enum logic [1:0] {W_IDLE, W_REQ, W_RESP} w_state_e;

    localparam logic GNT_IFU = 1'b0;
    localparam logic GNT_LSU = 1'b1;

    r_state_e              r_state_q, r_state_d;
    logic                  r_gnt_q, r_gnt_d;
    logic [ADDR_WIDTH-1:0] ar_addr_q, ar_addr_d;
    logic [PORT_WIDTH-1:0] ar_port_q, ar_port_d;
    logic                  r_win;
    logic                  r_rdy;
`ifdef AXI_ARB_RR_EN
    logic                  r_last_q, r_last_d;
`endif

    w_state_e              w_state_q, w_state_d;
    logic                  aw_done_q, aw_done_d;
    logic                  w_done_q, w_done_d;
    logic [ADDR_WIDTH-1:0] aw_addr_q, aw_addr_d;
    logic [PORT_WIDTH-1:0] aw_port_q, aw_port_d;
    logic [STRB_WIDTH-1:0] w_strb_q, w_strb_d;
    logic [DATA_WIDTH-1:0] w_data_q, w_data_d;
    logic                  aw_all, w_all;

    // Read path: arbitration, address issue and R routing to the granted requester
    always_comb begin
        r_state_d      = r_state_q;
        r_gnt_d        = r_gnt_q;
        ar_addr_d      = ar_addr_q;
        ar_port_d      = ar_port_q;
`ifdef AXI_ARB_RR_EN
        r_last_d       = r_last_q;
`endif
        r_win          = GNT_IFU;
        r_rdy          = 1'b0;
        ifu_ar_ready_o = 1'b0;
        lsu_ar_ready_o = 1'b0;
        ifu_r_valid_o  = 1'b0;
        ifu_r_resp_o   = '0;
        ifu_r_data_o   = '0;
        lsu_r_valid_o  = 1'b0;
        lsu_r_resp_o   = '0;
        lsu_r_data_o   = '0;
        axi_ar_valid_o = 1'b0;
        axi_ar_port_o  = '0;
        axi_ar_addr_o  = '0;
        axi_r_ready_o  = 1'b0;
        case (r_state_q)
            R_IDLE: begin
                // ready is combinational, so mask it while reset is held
                if (areset_n && (ifu_ar_valid_i || lsu_ar_valid_i)) begin
                    if (ifu_ar_valid_i && lsu_ar_valid_i) begin
`ifdef AXI_ARB_RR_EN
                        r_win = ~r_last_q;
`else
                        r_win = GNT_LSU;
`endif
                    end else begin
                        r_win = lsu_ar_valid_i ? GNT_LSU : GNT_IFU;
                    end
                    if (r_win == GNT_LSU) begin
                        lsu_ar_ready_o = 1'b1;
                        ar_addr_d      = lsu_ar_addr_i;
                        ar_port_d      = lsu_ar_port_i;
                    end else begin
                        ifu_ar_ready_o = 1'b1;
                        ar_addr_d      = ifu_ar_addr_i;
                        ar_port_d      = ifu_ar_port_i;
                    end
                    r_gnt_d = r_win;
`ifdef AXI_ARB_RR_EN
                    r_last_d = r_win;
`endif
                    r_state_d = R_ADDR;
                end
            end
            R_ADDR: begin
                axi_ar_valid_o = 1'b1;
                axi_ar_port_o  = ar_port_q;
                axi_ar_addr_o  = ar_addr_q;
                if (axi_ar_ready_i) begin
                    r_state_d = R_DATA;
                end
            end
            R_DATA: begin
                if (r_gnt_q == GNT_LSU) begin
                    lsu_r_valid_o = axi_r_valid_i;
                    lsu_r_resp_o  = axi_r_resp_i;
                    lsu_r_data_o  = axi_r_data_i;
                    r_rdy         = lsu_r_ready_i;
                end else begin
                    ifu_r_valid_o = axi_r_valid_i;
                    ifu_r_resp_o  = axi_r_resp_i;
                    ifu_r_data_o  = axi_r_data_i;
                    r_rdy         = ifu_r_ready_i;
                end
                axi_r_ready_o = r_rdy;
                if (axi_r_valid_i && r_rdy) begin
                    r_state_d = R_IDLE;
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    // Write path: accept aw+w together, issue both downstream, forward B
    always_comb begin
        w_state_d      = w_state_q;
        aw_done_d      = aw_done_q;
        w_done_d       = w_done_q;
        aw_addr_d      = aw_addr_q;
        aw_port_d      = aw_port_q;
        w_strb_d       = w_strb_q;
        w_data_d       = w_data_q;
        aw_all         = 1'b0;
        w_all          = 1'b0;
        lsu_aw_ready_o = 1'b0;
        lsu_w_ready_o  = 1'b0;
        lsu_b_valid_o  = 1'b0;
        lsu_b_resp_o   = '0;
        axi_aw_valid_o = 1'b0;
        axi_aw_port_o  = '0;
        axi_aw_addr_o  = '0;
        axi_w_valid_o  = 1'b0;
        axi_w_strb_o   = '0;
        axi_w_data_o   = '0;
        axi_b_ready_o  = 1'b0;
        case (w_state_q)
            W_IDLE: begin
                if (areset_n && lsu_aw_valid_i && lsu_w_valid_i) begin
                    lsu_aw_ready_o = 1'b1;
                    lsu_w_ready_o  = 1'b1;
                    aw_addr_d      = lsu_aw_addr_i;
                    aw_port_d      = lsu_aw_port_i;
                    w_strb_d       = lsu_w_strb_i;
                    w_data_d       = lsu_w_data_i;
                    w_state_d      = W_REQ;
                end
            end
            W_REQ: begin
                axi_aw_valid_o = ~aw_done_q;
                axi_w_valid_o  = ~w_done_q;
                if (!aw_done_q) begin
                    axi_aw_port_o = aw_port_q;
                    axi_aw_addr_o = aw_addr_q;
                end
                if (!w_done_q) begin
                    axi_w_strb_o = w_strb_q;
                    axi_w_data_o = w_data_q;
                end
                aw_all = aw_done_q | axi_aw_ready_i;
                w_all  = w_done_q | axi_w_ready_i;
                if (aw_all && w_all) begin
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    w_state_d = W_RESP;
                end else begin
                    aw_done_d = aw_all;
                    w_done_d  = w_all;
                end
            end
            W_RESP: begin
                lsu_b_valid_o = axi_b_valid_i;
                lsu_b_resp_o  = axi_b_resp_i;
                axi_b_ready_o = lsu_b_ready_i;
                if (axi_b_valid_i && lsu_b_ready_i) begin
                    w_state_d = W_IDLE;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    // State and latched-request registers, synchronous active-low reset
    always_ff @(posedge aclk) begin
        if (!areset_n) begin
            r_state_q <= R_IDLE;
            r_gnt_q   <= GNT_IFU;
            ar_addr_q <= '0;
            ar_port_q <= '0;
`ifdef AXI_ARB_RR_EN
            r_last_q  <= GNT_IFU;
`endif
            w_state_q <= W_IDLE;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            aw_addr_q <= '0;
            aw_port_q <= '0;
            w_strb_q  <= '0;
            w_data_q  <= '0;
        end else begin
            r_state_q <= r_state_d;
            r_gnt_q   <= r_gnt_d;
            ar_addr_q <= ar_addr_d;
            ar_port_q <= ar_port_d;
`ifdef AXI_ARB_RR_EN
            r_last_q  <= r_last_d;
`endif
            w_state_q <= w_state_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            aw_addr_q <= aw_addr_d;
            aw_port_q <= aw_port_d;
            w_strb_q  <= w_strb_d;
            w_data_q  <= w_data_d;
        end
    end

endmodule

// File: tb/tb_ysyx_23060077_riscv_axi_arbiter.sv
// Bench for the AXI arbiter: requester and slave driver tasks, scoreboard of served reads/writes.
module tb_ysyx_23060077_riscv_axi_arbiter;

    logic        aclk = 1'b0;
    logic        areset_n;
    logic        ifu_ar_valid_i, ifu_ar_ready_o, ifu_r_valid_o, ifu_r_ready_i;
    logic [2:0]  ifu_ar_port_i;
    logic [31:0] ifu_ar_addr_i, ifu_r_data_o;
    logic [1:0]  ifu_r_resp_o;
    logic        lsu_ar_valid_i, lsu_ar_ready_o, lsu_r_valid_o, lsu_r_ready_i;
    logic [2:0]  lsu_ar_port_i;
    logic [31:0] lsu_ar_addr_i, lsu_r_data_o;
    logic [1:0]  lsu_r_resp_o;
    logic        lsu_aw_valid_i, lsu_aw_ready_o, lsu_w_valid_i, lsu_w_ready_o;
    logic [2:0]  lsu_aw_port_i;
    logic [31:0] lsu_aw_addr_i, lsu_w_data_i;
    logic [3:0]  lsu_w_strb_i;
    logic        lsu_b_valid_o, lsu_b_ready_i;
    logic [1:0]  lsu_b_resp_o;
    logic        axi_ar_valid_o, axi_ar_ready_i, axi_r_valid_i, axi_r_ready_o;
    logic [2:0]  axi_ar_port_o;
    logic [31:0] axi_ar_addr_o, axi_r_data_i;
    logic [1:0]  axi_r_resp_i;
    logic        axi_aw_valid_o, axi_aw_ready_i, axi_w_valid_o, axi_w_ready_i;
    logic [2:0]  axi_aw_port_o;
    logic [31:0] axi_aw_addr_o, axi_w_data_o;
    logic [3:0]  axi_w_strb_o;
    logic        axi_b_valid_i, axi_b_ready_o;
    logic [1:0]  axi_b_resp_i;

    ysyx_23060077_riscv_axi_arbiter dut (
        .aclk(aclk), .areset_n(areset_n),
        .ifu_ar_valid_i(ifu_ar_valid_i), .ifu_ar_ready_o(ifu_ar_ready_o),
        .ifu_ar_port_i(ifu_ar_port_i), .ifu_ar_addr_i(ifu_ar_addr_i),
        .ifu_r_valid_o(ifu_r_valid_o), .ifu_r_ready_i(ifu_r_ready_i),
        .ifu_r_resp_o(ifu_r_resp_o), .ifu_r_data_o(ifu_r_data_o),
        .lsu_ar_valid_i(lsu_ar_valid_i), .lsu_ar_ready_o(lsu_ar_ready_o),
        .lsu_ar_port_i(lsu_ar_port_i), .lsu_ar_addr_i(lsu_ar_addr_i),
        .lsu_r_valid_o(lsu_r_valid_o), .lsu_r_ready_i(lsu_r_ready_i),
        .lsu_r_resp_o(lsu_r_resp_o), .lsu_r_data_o(lsu_r_data_o),
        .lsu_aw_valid_i(lsu_aw_valid_i), .lsu_aw_ready_o(lsu_aw_ready_o),
        .lsu_aw_port_i(lsu_aw_port_i), .lsu_aw_addr_i(lsu_aw_addr_i),
        .lsu_w_valid_i(lsu_w_valid_i), .lsu_w_ready_o(lsu_w_ready_o),
        .lsu_w_strb_i(lsu_w_strb_i), .lsu_w_data_i(lsu_w_data_i),
        .lsu_b_valid_o(lsu_b_valid_o), .lsu_b_ready_i(lsu_b_ready_i),
        .lsu_b_resp_o(lsu_b_resp_o),
        .axi_ar_valid_o(axi_ar_valid_o), .axi_ar_ready_i(axi_ar_ready_i),
        .axi_ar_port_o(axi_ar_port_o), .axi_ar_addr_o(axi_ar_addr_o),
        .axi_r_valid_i(axi_r_valid_i), .axi_r_ready_o(axi_r_ready_o),
        .axi_r_resp_i(axi_r_resp_i), .axi_r_data_i(axi_r_data_i),
        .axi_aw_valid_o(axi_aw_valid_o), .axi_aw_ready_i(axi_aw_ready_i),
        .axi_aw_port_o(axi_aw_port_o), .axi_aw_addr_o(axi_aw_addr_o),
        .axi_w_valid_o(axi_w_valid_o), .axi_w_ready_i(axi_w_ready_i),
        .axi_w_strb_o(axi_w_strb_o), .axi_w_data_o(axi_w_data_o),
        .axi_b_valid_i(axi_b_valid_i), .axi_b_ready_o(axi_b_ready_o),
        .axi_b_resp_i(axi_b_resp_i)
    );

    always #5 aclk = ~aclk;

    logic [187:0] all_out;
    assign all_out = {ifu_ar_ready_o, ifu_r_valid_o, ifu_r_resp_o, ifu_r_data_o,
                      lsu_ar_ready_o, lsu_r_valid_o, lsu_r_resp_o, lsu_r_data_o,
                      lsu_aw_ready_o, lsu_w_ready_o, lsu_b_valid_o, lsu_b_resp_o,
                      axi_ar_valid_o, axi_ar_port_o, axi_ar_addr_o, axi_r_ready_o,
                      axi_aw_valid_o, axi_aw_port_o, axi_aw_addr_o,
                      axi_w_valid_o, axi_w_strb_o, axi_w_data_o, axi_b_ready_o};

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [1:0]  resp;
    } rd_t;

    rd_t        sb_q[$];
    rd_t        got_q[$];
    logic [1:0] sb_b[$];
    logic [1:0] got_b[$];

    int checks = 0;
    int fails  = 0;
    int cyc    = 0;
    int tmo    = 0;
    int acc_cyc;
    int ar_seen_cyc;
    int aw_n, w_n;
    logic [31:0] cap_aw_addr, cap_w_data;
    logic [2:0]  cap_aw_port;
    logic [3:0]  cap_w_strb;

    always @(posedge aclk) cyc <= cyc + 1;

    // Drive point: 1 time unit after the rising edge; samples are taken 1 unit later.
    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    task automatic idle_inputs();
        ifu_ar_valid_i = 0; ifu_ar_port_i = 0; ifu_ar_addr_i = 0; ifu_r_ready_i = 0;
        lsu_ar_valid_i = 0; lsu_ar_port_i = 0; lsu_ar_addr_i = 0; lsu_r_ready_i = 0;
        lsu_aw_valid_i = 0; lsu_aw_port_i = 0; lsu_aw_addr_i = 0;
        lsu_w_valid_i = 0; lsu_w_strb_i = 0; lsu_w_data_i = 0; lsu_b_ready_i = 0;
        axi_ar_ready_i = 0; axi_r_valid_i = 0; axi_r_resp_i = 0; axi_r_data_i = 0;
        axi_aw_ready_i = 0; axi_w_ready_i = 0; axi_b_valid_i = 0; axi_b_resp_i = 0;
    endtask

    // Requester: n back-to-back reads from base, each result appended to got_q.
    task automatic master_rd(input bit is_lsu, input logic [31:0] base, input int n);
        for (int k = 0; k < n; k++) begin
            bit   ok = 0;
            rd_t  g;
            g.addr = base + 32'(k * 4);
            if (is_lsu) begin
                lsu_ar_valid_i = 1; lsu_ar_addr_i = g.addr; lsu_ar_port_i = 3'(k);
            end else begin
                ifu_ar_valid_i = 1; ifu_ar_addr_i = g.addr; ifu_ar_port_i = 3'(k);
            end
            for (int i = 0; i < 80 && !ok; i++) begin
                #1;
                if (is_lsu ? lsu_ar_ready_o : ifu_ar_ready_o) begin
                    ok = 1;
                    if (k == 0) acc_cyc = cyc;
                end
                step();
            end
            if (is_lsu) lsu_ar_valid_i = 0; else ifu_ar_valid_i = 0;
            if (!ok) begin tmo++; return; end
            ok = 0;
            if (is_lsu) lsu_r_ready_i = 1; else ifu_r_ready_i = 1;
            for (int i = 0; i < 80 && !ok; i++) begin
                #1;
                if (is_lsu ? lsu_r_valid_o : ifu_r_valid_o) begin
                    ok = 1;
                    g.data = is_lsu ? lsu_r_data_o : ifu_r_data_o;
                    g.resp = is_lsu ? lsu_r_resp_o : ifu_r_resp_o;
                end
                step();
            end
            if (is_lsu) lsu_r_ready_i = 0; else ifu_r_ready_i = 0;
            if (!ok) begin tmo++; return; end
            got_q.push_back(g);
        end
    endtask

    // Downstream read slave: serves n reads, data derived from address, pushes what it sent.
    task automatic slave_rd(input int n, input logic [1:0] resp);
        for (int k = 0; k < n; k++) begin
            bit  ok = 0;
            rd_t e;
            for (int i = 0; i < 200 && !ok; i++) begin
                #1;
                if (axi_ar_valid_o) begin
                    ok = 1;
                    if (ar_seen_cyc < 0) ar_seen_cyc = cyc;
                    e.addr = axi_ar_addr_o;
                    axi_ar_ready_i = 1;
                end
                step();
            end
            axi_ar_ready_i = 0;
            if (!ok) begin tmo++; return; end
            e.data = e.addr ^ 32'h8000_0013;
            e.resp = resp;
            sb_q.push_back(e);
            axi_r_valid_i = 1; axi_r_data_i = e.data; axi_r_resp_i = resp;
            ok = 0;
            for (int i = 0; i < 80 && !ok; i++) begin
                #1;
                if (axi_r_ready_o) ok = 1;
                step();
            end
            axi_r_valid_i = 0; axi_r_data_i = 0; axi_r_resp_i = 0;
            if (!ok) begin tmo++; return; end
        end
    endtask

    task automatic master_wr(input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input logic [2:0] port);
        bit ok = 0;
        lsu_aw_valid_i = 1; lsu_aw_addr_i = addr; lsu_aw_port_i = port;
        lsu_w_valid_i = 1; lsu_w_data_i = data; lsu_w_strb_i = strb;
        for (int i = 0; i < 40 && !ok; i++) begin
            #1;
            if (lsu_aw_ready_o && lsu_w_ready_o) ok = 1;
            step();
        end
        lsu_aw_valid_i = 0; lsu_w_valid_i = 0;
        if (!ok) begin tmo++; return; end
        ok = 0;
        lsu_b_ready_i = 1;
        for (int i = 0; i < 60 && !ok; i++) begin
            #1;
            if (lsu_b_valid_o) begin ok = 1; got_b.push_back(lsu_b_resp_o); end
            step();
        end
        lsu_b_ready_i = 0;
        if (!ok) tmo++;
        for (int i = 0; i < 3; i++) begin
            #1;
            if (lsu_b_valid_o) got_b.push_back(lsu_b_resp_o);
            step();
        end
    endtask

    // Downstream write slave: aw/w ready from the given cycle on, then one B beat.
    task automatic slave_wr(input int awd, input int wd, input logic [1:0] bresp);
        bit ok = 0;
        aw_n = 0; w_n = 0;
        for (int c = 0; c < 12; c++) begin
            axi_aw_ready_i = (c >= awd);
            axi_w_ready_i  = (c >= wd);
            #1;
            if (axi_aw_valid_o && axi_aw_ready_i) begin
                aw_n++; cap_aw_addr = axi_aw_addr_o; cap_aw_port = axi_aw_port_o;
            end
            if (axi_w_valid_o && axi_w_ready_i) begin
                w_n++; cap_w_data = axi_w_data_o; cap_w_strb = axi_w_strb_o;
            end
            step();
        end
        axi_aw_ready_i = 0; axi_w_ready_i = 0;
        axi_b_valid_i = 1; axi_b_resp_i = bresp;
        sb_b.push_back(bresp);
        for (int i = 0; i < 40 && !ok; i++) begin
            #1;
            if (axi_b_ready_o) ok = 1;
            step();
        end
        axi_b_valid_i = 0; axi_b_resp_i = 0;
        if (!ok) tmo++;
    endtask

    task automatic test_reset();
        idle_inputs();
        areset_n = 0;
        step(); step();
        #1;
        checks++;
        if (all_out !== '0) begin
            fails++; $display("FAIL reset_hold: outputs %h, required 0", all_out);
        end
        areset_n = 1;
        step(); #1;
        checks++;
        if (all_out !== '0) begin
            fails++; $display("FAIL reset_release: outputs %h, required 0", all_out);
        end
        step();
    endtask

    task automatic test_ifu_read();
        rd_t e, g;
        bit  lsu_seen = 0;
        tmo = 0; ar_seen_cyc = -1; acc_cyc = -10;
        fork
            master_rd(1'b0, 32'h8000_0000, 1);
            slave_rd(1, 2'b00);
            begin
                for (int i = 0; i < 10; i++) begin
                    #1; if (lsu_r_valid_o) lsu_seen = 1;
                    step();
                end
            end
        join
        checks++;
        if (tmo !== 0) begin fails++; $display("FAIL ifu_rd_timeout: %0d timeouts, required 0", tmo); end
        checks++;
        if (got_q.size() !== 1 || sb_q.size() !== 1) begin
            fails++; $display("FAIL ifu_rd_count: got %0d served %0d, required 1/1", got_q.size(), sb_q.size());
        end else begin
            e = sb_q.pop_front(); g = got_q.pop_front();
            checks++;
            if (g.data !== 32'h0000_0013 || g.addr !== e.addr || g.resp !== 2'b00) begin
                fails++; $display("FAIL ifu_rd_data: addr %h data %h resp %h, required addr %h data 00000013 resp 0",
                                  g.addr, g.data, g.resp, e.addr);
            end
        end
        checks++;
        if (ar_seen_cyc !== acc_cyc + 1) begin
            fails++; $display("FAIL ifu_rd_latency: ar_valid at cycle %0d, required %0d", ar_seen_cyc, acc_cyc + 1);
        end
        checks++;
        if (lsu_seen !== 1'b0) begin fails++; $display("FAIL ifu_rd_crosstalk: lsu_r_valid_o seen %0b, required 0", lsu_seen); end
        sb_q.delete(); got_q.delete();
    endtask

    task automatic test_contention();
        logic [31:0] exp_ord[6];
        rd_t e, g;
`ifdef AXI_ARB_RR_EN
        exp_ord = '{32'h8000_1000, 32'h8000_0000, 32'h8000_1004, 32'h8000_0004, 32'h8000_1008, 32'h8000_0008};
`else
        exp_ord = '{32'h8000_1000, 32'h8000_1004, 32'h8000_1008, 32'h8000_0000, 32'h8000_0004, 32'h8000_0008};
`endif
        tmo = 0;
        fork
            master_rd(1'b0, 32'h8000_0000, 3);
            master_rd(1'b1, 32'h8000_1000, 3);
            slave_rd(6, 2'b00);
        join
        checks++;
        if (tmo !== 0 || sb_q.size() !== 6 || got_q.size() !== 6) begin
            fails++; $display("FAIL arb_count: tmo %0d served %0d got %0d, required 0/6/6", tmo, sb_q.size(), got_q.size());
        end
        for (int k = 0; k < 6 && sb_q.size() > 0 && got_q.size() > 0; k++) begin
            e = sb_q.pop_front(); g = got_q.pop_front();
            checks++;
            if (e.addr !== exp_ord[k]) begin
                fails++; $display("FAIL arb_order[%0d]: served %h, required %h", k, e.addr, exp_ord[k]);
            end
            checks++;
            if (g.addr !== e.addr || g.data !== e.data || g.resp !== e.resp) begin
                fails++; $display("FAIL arb_route[%0d]: got addr %h data %h, required addr %h data %h",
                                  k, g.addr, g.data, e.addr, e.data);
            end
        end
        sb_q.delete(); got_q.delete();
    endtask

    task automatic test_write();
        tmo = 0;
        lsu_aw_valid_i = 1; lsu_aw_addr_i = 32'h1234_0000;
        #1;
        checks++;
        if (lsu_aw_ready_o !== 1'b0 || lsu_w_ready_o !== 1'b0) begin
            fails++; $display("FAIL wr_aw_only: aw_ready %0b w_ready %0b, required 0/0", lsu_aw_ready_o, lsu_w_ready_o);
        end
        step();
        lsu_aw_valid_i = 0; lsu_aw_addr_i = 0;
        step();
        fork
            master_wr(32'hA000_03F8, 32'h0000_0041, 4'h1, 3'd2);
            slave_wr(1, 3, 2'b00);
        join
        checks++;
        if (tmo !== 0 || aw_n !== 1 || w_n !== 1) begin
            fails++; $display("FAIL wr_count: tmo %0d aw %0d w %0d, required 0/1/1", tmo, aw_n, w_n);
        end
        checks++;
        if (cap_aw_addr !== 32'hA000_03F8 || cap_aw_port !== 3'd2 || cap_w_data !== 32'h41 || cap_w_strb !== 4'h1) begin
            fails++; $display("FAIL wr_fields: addr %h port %0d data %h strb %h, required a00003f8/2/00000041/1",
                              cap_aw_addr, cap_aw_port, cap_w_data, cap_w_strb);
        end
        checks++;
        if (got_b.size() !== 1 || sb_b.size() !== 1) begin
            fails++; $display("FAIL wr_b_once: got %0d B, required 1", got_b.size());
        end else if (got_b[0] !== sb_b[0]) begin
            fails++; $display("FAIL wr_b_resp: got %0d, required %0d", got_b[0], sb_b[0]);
        end
        got_b.delete(); sb_b.delete();
    endtask

    task automatic test_concurrent();
        rd_t e, g;
        tmo = 0;
        fork
            master_wr(32'hA000_0100, 32'hDEAD_BEEF, 4'hF, 3'd1);
            slave_wr(2, 1, 2'b11);
            master_rd(1'b0, 32'h8000_0040, 1);
            slave_rd(1, 2'b00);
        join
        checks++;
        if (tmo !== 0 || aw_n !== 1 || w_n !== 1) begin
            fails++; $display("FAIL conc_count: tmo %0d aw %0d w %0d, required 0/1/1", tmo, aw_n, w_n);
        end
        checks++;
        if (got_b.size() !== 1 || sb_b.size() !== 1) begin
            fails++; $display("FAIL conc_b_count: got %0d B, required 1", got_b.size());
        end else if (got_b[0] !== 2'b11) begin
            fails++; $display("FAIL conc_b_resp: got %0d, required 3", got_b[0]);
        end
        checks++;
        if (got_q.size() !== 1 || sb_q.size() !== 1) begin
            fails++; $display("FAIL conc_r_count: got %0d, required 1", got_q.size());
        end else begin
            e = sb_q.pop_front(); g = got_q.pop_front();
            if (g.addr !== 32'h8000_0040 || g.data !== e.data) begin
                fails++; $display("FAIL conc_r_data: addr %h data %h, required 80000040 %h", g.addr, g.data, e.data);
            end
        end
        sb_q.delete(); got_q.delete(); got_b.delete(); sb_b.delete();
    endtask

    task automatic test_resp_err();
        rd_t e, g;
        tmo = 0;
        fork
            master_rd(1'b1, 32'h8000_2000, 2);
            slave_rd(2, 2'b10);
        join
        checks++;
        if (tmo !== 0 || got_q.size() !== 2) begin
            fails++; $display("FAIL slverr_count: tmo %0d got %0d, required 0/2", tmo, got_q.size());
        end
        while (sb_q.size() > 0 && got_q.size() > 0) begin
            e = sb_q.pop_front(); g = got_q.pop_front();
            checks++;
            if (g.resp !== 2'b10 || g.data !== e.data || g.addr !== e.addr) begin
                fails++; $display("FAIL slverr_resp: resp %0d data %h, required 2 %h", g.resp, g.data, e.data);
            end
        end
        sb_q.delete(); got_q.delete();
    endtask

    task automatic test_reset_mid();
        rd_t e, g;
        ifu_ar_valid_i = 1; ifu_ar_addr_i = 32'h8000_0080; ifu_r_ready_i = 1;
        lsu_aw_valid_i = 1; lsu_aw_addr_i = 32'hA000_0000;
        lsu_w_valid_i = 1; lsu_w_data_i = 32'h55; lsu_w_strb_i = 4'hF;
        step();
        ifu_ar_valid_i = 0; lsu_aw_valid_i = 0; lsu_w_valid_i = 0;
        axi_ar_ready_i = 1;
        step();
        axi_ar_ready_i = 0;
        #1;
        checks++;
        if (axi_r_ready_o !== 1'b1 || axi_aw_valid_o !== 1'b1 || axi_w_valid_o !== 1'b1) begin
            fails++; $display("FAIL mid_setup: r_ready %0b aw_valid %0b w_valid %0b, required 1/1/1",
                              axi_r_ready_o, axi_aw_valid_o, axi_w_valid_o);
        end
        areset_n = 0;
        axi_r_valid_i = 1; axi_r_data_i = 32'hBAD0_BAD0;
        step();
        areset_n = 1;
        #1;
        checks++;
        if (all_out !== '0) begin
            fails++; $display("FAIL mid_reset_out: outputs %h, required 0", all_out);
        end
        step();
        #1;
        checks++;
        if (ifu_r_valid_o !== 1'b0 || axi_aw_valid_o !== 1'b0) begin
            fails++; $display("FAIL mid_reset_idle: ifu_r_valid %0b aw_valid %0b, required 0/0", ifu_r_valid_o, axi_aw_valid_o);
        end
        idle_inputs();
        step();
        tmo = 0;
        fork
            master_rd(1'b0, 32'h8000_0000, 1);
            slave_rd(1, 2'b00);
        join
        checks++;
        if (tmo !== 0 || got_q.size() !== 1) begin
            fails++; $display("FAIL mid_after: tmo %0d got %0d, required 0/1", tmo, got_q.size());
        end else begin
            e = sb_q.pop_front(); g = got_q.pop_front();
            checks++;
            if (g.data !== 32'h13 || g.addr !== e.addr) begin
                fails++; $display("FAIL mid_after_data: data %h, required 00000013", g.data);
            end
        end
        sb_q.delete(); got_q.delete();
    endtask

    initial begin
        idle_inputs();
        areset_n = 0;
        test_reset();
        test_ifu_read();
        test_contention();
        test_write();
        test_concurrent();
        test_resp_err();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
